complex_power_detect: RTL and testbench
=======================================

// Module: complex_power_detect
// PURPOSE
//  Consumes the 36-bit |I|^2+|Q|^2 power stream from the complex magnitude-squared stage.
//  Forms a sliding-window average over 2^LOG2_WIN samples.
//  Runs a debounced hysteresis state machine against on/off thresholds to flag signal presence.
//  Sits between the power stage and the burst/AGC control logic.
// PARAMETERS
//  LOG2_WIN  4  window length = 2^LOG2_WIN power samples (1..8)
//  DEB_CNT   4  consecutive averages required to enter or leave DETECT (1..255)
// PORTS
//  i_clk           in   1   clock; all logic on rising edge
//  i_rst_n         in   1   asynchronous, active-low reset
//  i_clear         in   1   synchronous flush: empty window, return to FILL
//  i_data_valid    in   1   i_data is valid this cycle
//  i_data          in   36  power sample, treated as UNSIGNED (max 2^35)
//  i_thr_on        in   36  unsigned enter threshold, sampled every cycle
//  i_thr_off       in   36  unsigned leave threshold, sampled every cycle
//  o_avg_valid     out  1   one-cycle strobe: o_avg_power updated
//  o_avg_power     out  36  window sum >> LOG2_WIN (truncating)
//  o_detect        out  1   high while in DETECT
//  o_detect_start  out  1   one-cycle pulse on SEARCH->DETECT
//  o_detect_end    out  1   one-cycle pulse on DETECT->SEARCH
// BEHAVIOUR
//  - Reset: all outputs 0; state FILL; sum, write pointer, fill count and debounce count all 0.
//    Window storage is not reset (RAM-inferable); it is never read before being written.
//  - Window: circular buffer of 2^LOG2_WIN x 36. Write pointer wraps modulo 2^LOG2_WIN.
//    Sum register is 36+LOG2_WIN bits and cannot overflow.
//  - Per accepted sample: sum <= sum + i_data - oldest. oldest = 0 while in FILL.
//    Sample overwrites oldest; pointer advances.
//  - Latency: o_avg_valid and new o_avg_power appear the cycle after the i_data_valid cycle.
//    o_avg_valid never asserts in FILL.
//  - FSM (evaluated on each o_avg_valid; o_detect/pulses registered, 1 cycle after o_avg_valid):
//    FILL:   count samples. The 2^LOG2_WIN-th sample -> SEARCH, and that sample yields the first o_avg_valid.
//    SEARCH: avg >= i_thr_on increments count, otherwise clears it.
//            Count reaching DEB_CNT -> DETECT, pulse o_detect_start, clear count.
//    DETECT: avg <  i_thr_off increments count, otherwise clears it.
//            Count reaching DEB_CNT -> SEARCH, pulse o_detect_end, clear count.
//  - The first average after FILL is evaluated like any other; it can count toward DEB_CNT.
//  - thr_off > thr_on is legal; the rules apply literally (no clamping).
//  - o_avg_power holds between strobes. Gaps in i_data_valid freeze all state.
//  - i_clear has priority over a simultaneous i_data_valid (that sample is dropped).
//    It zeroes sum, pointer, fill and debounce count, o_detect, and any pending pulse; state -> FILL.
//    No o_detect_end is generated. o_avg_power holds its last value.
//  - Reset mid-operation: immediate return to reset values; no pulses.
// CONFIGURATION
//  POWER_DETECT_PEAK_HOLD_EN defined:
//    - Adds port o_peak_power (out, 36).
//    - Loaded with the entering average on SEARCH->DETECT.
//    - Then max(o_peak_power, avg) on each o_avg_valid while in DETECT.
//    - Held after exit until the next entry. Reset and i_clear set it to 0.
//  Undefined: port and logic absent; all other behaviour identical.
// TESTING (LOG2_WIN=4, DEB_CNT=4)
//  1. Reset, 15 samples of 100 -> no o_avg_valid. 16th sample -> o_avg_valid next cycle, o_avg_power=100.
//  2. Constant 1000, thr_on=500, thr_off=200 -> averages from samples 16..19 are all 1000.
//     o_detect_start pulses and o_detect=1 one cycle after the 19th sample's o_avg_valid.
//  3. Continue from 2 with input 0 -> avg 937, 875, ... 13th zero gives 187.
//     16th zero (avg 0, 4th below 200) -> o_detect_end, o_detect=0.
//     Peak-hold build: o_peak_power=1000 and held.
//  4. Averages alternating 3x 600 then 1x 400 (thr_on=500), repeated 10 times -> o_detect never rises.
//  5. In DETECT, i_clear with i_data_valid same cycle -> o_detect=0 next cycle, no end pulse.
//     No o_avg_valid for the next 15 samples; the 16th produces it.
//  6. Window of 16 x 2^35 -> o_avg_power=2^35, no wrap.
//     Then i_rst_n low mid-stream -> all outputs 0 asynchronously; restart behaves as in 1.

Source files
------------

// File: rtl/complex_power_detect.sv
// complex_power_detect: sliding-window power average with a debounced
// hysteresis detector.
// Optional feature macro: POWER_DETECT_PEAK_HOLD_EN adds o_peak_power, which
// tracks the largest average seen during the current/last DETECT interval.
module complex_power_detect #(
  parameter int LOG2_WIN = 4,
  parameter int DEB_CNT  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_data_valid,
  input  logic [35:0] i_data,
  input  logic [35:0] i_thr_on,
  input  logic [35:0] i_thr_off,
  output logic        o_avg_valid,
  output logic [35:0] o_avg_power,
  output logic        o_detect,
  output logic        o_detect_start,
`ifdef POWER_DETECT_PEAK_HOLD_EN
  output logic        o_detect_end,
  output logic [35:0] o_peak_power
`else
  output logic        o_detect_end
`endif
);

  localparam int WIN = 1 << LOG2_WIN;
  localparam int SW  = 36 + LOG2_WIN;

  typedef enum logic [1:0] {S_FILL, S_SEARCH, S_DETECT} state_t;

  // window storage carries no reset so it can map onto RAM; FILL masks
  // the stale contents until every slot has been written once
  logic [35:0]         r_win [WIN];
  logic [SW-1:0]       r_sum;
  logic [LOG2_WIN-1:0] r_wptr;
  logic [LOG2_WIN-1:0] r_fill;
  logic [7:0]          r_cnt;
  state_t              r_state;
  logic                r_avg_valid;
  logic [35:0]         r_avg_power;
  logic                r_detect;
  logic                r_start;
  logic                r_end;

  logic [35:0]   w_oldest;
  logic [SW-1:0] w_sum_nxt;
  logic [35:0]   w_avg_nxt;
  logic          w_fill_last;
  logic          w_hit;
  logic [7:0]    w_cnt_inc;
  logic          w_deb_done;

  // oldest sample is 0 while the window is still filling
  assign w_oldest    = (r_state == S_FILL) ? '0 : r_win[r_wptr];
  // sum always contains w_oldest, so the subtraction cannot underflow
  assign w_sum_nxt   = r_sum + SW'(i_data) - SW'(w_oldest);
  assign w_avg_nxt   = w_sum_nxt[SW-1:LOG2_WIN];
  assign w_fill_last = (r_fill == LOG2_WIN'(WIN - 1));

  // hysteresis: SEARCH looks for strong averages, DETECT for weak ones
  assign w_hit      = (r_state == S_SEARCH) ? (r_avg_power >= i_thr_on)
                                            : (r_avg_power <  i_thr_off);
  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_deb_done = (w_cnt_inc == 8'(DEB_CNT));

  // window write; cleared-cycle samples are dropped
  always_ff @(posedge i_clk) begin
    if (i_data_valid && !i_clear) r_win[r_wptr] <= i_data;
  end

  // running sum, fill tracking, debounce FSM and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum       <= '0;
      r_wptr      <= '0;
      r_fill      <= '0;
      r_cnt       <= '0;
      r_state     <= S_FILL;
      r_avg_valid <= 1'b0;
      r_avg_power <= '0;
      r_detect    <= 1'b0;
      r_start     <= 1'b0;
      r_end       <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      r_start     <= 1'b0;
      r_end       <= 1'b0;
      if (i_clear) begin
        // flush everything except the last reported average
        r_sum    <= '0;
        r_wptr   <= '0;
        r_fill   <= '0;
        r_cnt    <= '0;
        r_state  <= S_FILL;
        r_detect <= 1'b0;
      end else begin
        // evaluate the average published last cycle (never in FILL)
        if (r_avg_valid) begin
          if (r_state == S_SEARCH || r_state == S_DETECT) begin
            if (!w_hit) begin
              r_cnt <= '0;
            end else if (w_deb_done) begin
              r_cnt <= '0;
              if (r_state == S_SEARCH) begin
                r_state  <= S_DETECT;
                r_detect <= 1'b1;
                r_start  <= 1'b1;
              end else begin
                r_state  <= S_SEARCH;
                r_detect <= 1'b0;
                r_end    <= 1'b1;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        // accept a new sample; FILL completes on the WIN-th sample
        if (i_data_valid) begin
          r_sum  <= w_sum_nxt;
          r_wptr <= r_wptr + LOG2_WIN'(1);
          if (r_state == S_FILL) begin
            r_fill <= r_fill + LOG2_WIN'(1);
            if (w_fill_last) begin
              r_state     <= S_SEARCH;
              r_avg_valid <= 1'b1;
              r_avg_power <= w_avg_nxt;
            end
          end else begin
            r_avg_valid <= 1'b1;
            r_avg_power <= w_avg_nxt;
          end
        end
      end
    end
  end

`ifdef POWER_DETECT_PEAK_HOLD_EN
  logic [35:0] r_peak;

  // load on entry, track the maximum while in DETECT, hold after exit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_peak <= '0;
    end else if (i_clear) begin
      r_peak <= '0;
    end else if (r_avg_valid) begin
      if (r_state == S_SEARCH && w_hit && w_deb_done)
        r_peak <= r_avg_power;
      else if (r_state == S_DETECT && r_avg_power > r_peak)
        r_peak <= r_avg_power;
    end
  end

  assign o_peak_power = r_peak;
`endif

  assign o_avg_valid    = r_avg_valid;
  assign o_avg_power    = r_avg_power;
  assign o_detect       = r_detect;
  assign o_detect_start = r_start;
  assign o_detect_end   = r_end;

endmodule

// File: tb/tb_complex_power_detect.sv
// Bench for complex_power_detect: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_complex_power_detect;
  localparam int L   = 4;
  localparam int N   = 1 << L;
  localparam int DEB = 4;
  localparam logic [35:0] BIG = 36'h8_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic        dv = 1'b0;
  logic [35:0] data = '0;
  logic [35:0] thr_on = '1;
  logic [35:0] thr_off = '0;
  logic        avg_valid, det, det_start, det_end;
  logic [35:0] avg_power;
`ifdef POWER_DETECT_PEAK_HOLD_EN
  logic [35:0] peak;
`endif

  int total = 0;
  int bad   = 0;

  complex_power_detect #(.LOG2_WIN(L), .DEB_CNT(DEB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_data_valid(dv),
    .i_data(data), .i_thr_on(thr_on), .i_thr_off(thr_off),
    .o_avg_valid(avg_valid), .o_avg_power(avg_power), .o_detect(det),
    .o_detect_start(det_start),
`ifdef POWER_DETECT_PEAK_HOLD_EN
    .o_detect_end(det_end), .o_peak_power(peak)
`else
    .o_detect_end(det_end)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // window = last N accepted samples since clear/reset; an average exists
  // once N samples are present; detection is a debounced two-threshold flag
  logic [35:0] q[$];
  bit          m_av, m_det, m_st, m_en;
  logic [35:0] m_avg, m_peak;
  int          m_cnt;

  always @(posedge clk) begin
    bit     nav;
    longint s;
    if (!rst_n) begin
      q.delete();
      m_av = 0; m_avg = '0; m_det = 0; m_st = 0; m_en = 0; m_cnt = 0; m_peak = '0;
    end else begin
      m_st = 0; m_en = 0; nav = 0;
      if (clear) begin
        q.delete();
        m_det = 0; m_cnt = 0; m_peak = '0;
      end else begin
        if (m_av) begin
          if (!m_det) begin
            m_cnt = (m_avg >= thr_on) ? m_cnt + 1 : 0;
            if (m_cnt == DEB) begin m_det = 1; m_st = 1; m_cnt = 0; m_peak = m_avg; end
          end else begin
            if (m_avg > m_peak) m_peak = m_avg;
            m_cnt = (m_avg < thr_off) ? m_cnt + 1 : 0;
            if (m_cnt == DEB) begin m_det = 0; m_en = 1; m_cnt = 0; end
          end
        end
        if (dv) begin
          q.push_back(data);
          if (q.size() > N) void'(q.pop_front());
          if (q.size() == N) begin
            s = 0;
            foreach (q[i]) s += longint'(q[i]);
            nav = 1;
            m_avg = 36'(s / N);
          end
        end
      end
      m_av = nav;
    end
    #1;
    chk("avg_valid", avg_valid, m_av);
    chk("avg_power", avg_power, m_avg);
    chk("detect", det, m_det);
    chk("detect_start", det_start, m_st);
    chk("detect_end", det_end, m_en);
`ifdef POWER_DETECT_PEAK_HOLD_EN
    chk("peak_power", peak, m_peak);
`endif
  end

  // ---------------- stimulus (driven just after negedge) ----------------
  task automatic send(input logic [35:0] d);
    dv = 1'b1; data = d;
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr(input bit with_valid);
    clear = 1'b1; dv = with_valid; data = 36'd1000;
    @(negedge clk);
    clear = 1'b0; dv = 1'b0;
  endtask

  task automatic fill_check_100();
    thr_on = '1; thr_off = '0;
    repeat (15) send(36'd100);
    chk("fill15_no_valid", avg_valid, 0);
    send(36'd100);
    chk("fill16_valid", avg_valid, 1);
    chk("fill16_avg", avg_power, 100);
  endtask

  initial begin
    logic [35:0] base;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_avg_power", avg_power, 0);
    chk("rst_detect", det, 0);
    rst_n = 1'b1;

    // 1: first average only on the 16th sample
    fill_check_100();

    // 2: constant 1000 enters DETECT after the 4th average
    thr_on = 36'd500; thr_off = 36'd200;
    clr(0);
    repeat (18) send(36'd1000);
    chk("s2_not_yet", det, 0);
    send(36'd1000);
    chk("s2_avg19", avg_power, 1000);
    tick();
    chk("s2_start", det_start, 1);
    chk("s2_detect", det, 1);

    // 3: zeros decay the average; the 16th zero is the 4th below thr_off
    for (int k = 1; k <= 16; k++) begin
      send(36'd0);
      if (k == 1)  chk("s3_avg937", avg_power, 937);
      if (k == 13) chk("s3_avg187", avg_power, 187);
    end
    chk("s3_avg0", avg_power, 0);
    chk("s3_still_det", det, 1);
    tick();
    chk("s3_end", det_end, 1);
    chk("s3_detect_low", det, 0);
`ifdef POWER_DETECT_PEAK_HOLD_EN
    chk("s3_peak", peak, 1000);
`endif

    // 4: every 4th evaluation fails thr_on (avg 600 against 700 behaves as
    //    avg 400 against 500), so the debounce count never reaches 4
    thr_on = 36'd500;
    clr(0);
    repeat (15) send(36'd600);
    for (int i = 0; i < 40; i++) begin
      send(36'd600);
      thr_on = (i % 4 == 3) ? 36'd700 : 36'd500;
      tick();
    end
    thr_on = 36'd500;
    chk("s4_never_det", det, 0);

    // 5: clear beats a same-cycle sample; no end pulse; refill needs 16
    clr(0);
    repeat (19) send(36'd1000);
    tick();
    chk("s5_in_det", det, 1);
    clr(1);
    chk("s5_det_clr", det, 0);
    chk("s5_no_end", det_end, 0);
    chk("s5_avg_hold", avg_power, 1000);
    repeat (15) send(36'd5);
    chk("s5_fill15", avg_valid, 0);
    send(36'd5);
    chk("s5_fill16", avg_valid, 1);
    chk("s5_avg5", avg_power, 5);

    // 6: full-scale window, then asynchronous reset mid-stream
    clr(0);
    repeat (16) send(BIG);
    chk("s6_big_avg", avg_power, BIG);
    send(BIG);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", avg_valid, 0);
    chk("s6_rst_avg", avg_power, 0);
    chk("s6_rst_det", det, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fill_check_100();

    // randomized traffic with alternating strong/weak phases
    base = 36'd1500;
    for (int c = 0; c < 4000; c++) begin
      int r;
      if (c % 500 == 0) begin
        thr_on  = 36'($urandom_range(500, 1500));
        thr_off = 36'($urandom_range(100, 1200));
      end
      if (c % 60 == 0) base = (base > 36'd500) ? 36'($urandom_range(0, 300))
                                               : 36'($urandom_range(1200, 2000));
      r = int'($urandom_range(0, 999));
      if (r < 4)
        clr(bit'($urandom_range(0, 1)));
      else if (r < 700)
        send(($urandom_range(0, 49) == 0) ? BIG : base + 36'($urandom_range(0, 200)));
      else
        tick();
    end
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
